reference_model: RTL and testbench
==================================

Name: reference_model

Overview:
- Cycle-accurate decode model of the 8237-style DMA controller's CPU programming interface.
- Watches chip-select, I/O strobes and the low address nibble while the DMA is in program condition (slave mode), and produces one-cycle register load/read strobes plus the byte-pointer flip-flop state.
- Sits beside the DMA datapath; checkers compare its strobes against the controller's register updates.

Parameters:
- none

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- CS_N  input  1  chip select, active low
- IOR_N  input  1  I/O read strobe, active low
- IOW_N  input  1  I/O write strobe, active low
- A3  input  1  address bit 3
- A2  input  1  address bit 2
- A1  input  1  address bit 1
- A0  input  1  address bit 0
- programCondition  input  1  DMA idle and CPU owns bus (register access allowed)
- loadBaseAddressReg  output  1  write base+current address register of channel
- loadBaseWordCountReg  output  1  write base+current word count register of channel
- readCurrentAddressReg  output  1  read current address register of channel
- readCurrentWordCountReg  output  1  read current word count register of channel
- channelSelect  output  2  channel addressed by A2:A1, registered with strobes
- loadCommandReg  output  1  write command register
- loadRequestReg  output  1  write request register
- loadSingleMask  output  1  write single mask bit
- loadModeReg  output  1  write mode register
- clearInternalFF  output  1  clear byte-pointer flip-flop
- masterClear  output  1  master clear
- clearMaskReg  output  1  clear all mask bits
- loadAllMask  output  1  write all mask bits
- readStatusReg  output  1  read status register
- readTemporaryReg  output  1  read temporary register
- loadIoDataBufferFromStatus  output  1  equals readStatusReg
- internalFF  output  1  byte pointer: 0 = low byte, 1 = high byte

Behaviour:
- Access qualification:
  - access = !CS_N && programCondition.
  - wr = access && !IOW_N && IOR_N.
  - rd = access && !IOR_N && IOW_N.
  - IOR_N and IOW_N both low: no strobe, internalFF unchanged.
- All strobe outputs are registered: decoded at cycle t, asserted during cycle t+1 only, so the datapath loads from ioDataBuffer captured at t.
- A held strobe re-decodes every cycle (level-in, level-out, one cycle delayed).
- Write decode (A3..A0):
  - 0xxx with A0=0: loadBaseAddressReg.
  - 0xxx with A0=1: loadBaseWordCountReg.
  - 1000 loadCommandReg; 1001 loadRequestReg; 1010 loadSingleMask; 1011 loadModeReg.
  - 1100 clearInternalFF; 1101 masterClear; 1110 clearMaskReg; 1111 loadAllMask.
- Read decode:
  - 0xxx with A0=0: readCurrentAddressReg.
  - 0xxx with A0=1: readCurrentWordCountReg.
  - 1000 readStatusReg; 1101 readTemporaryReg.
  - Other read addresses: no strobe.
- channelSelect = registered {A2,A1}, updated on every qualified channel-register access; holds otherwise.
- At most one strobe is high in any cycle.
- internalFF register:
  - Toggles on the clock edge ending each qualified channel-register access (any 0xxx read or write).
  - Forced to 0 on a clearInternalFF or masterClear decode; clear has priority over toggle.
  - A strobe held for N cycles toggles N times.
- Reset: RESET high asynchronously drives all strobes, channelSelect and internalFF to 0; they stay 0 while RESET is high. The first decode occurs on the first rising edge after deassertion.
- Reset mid-access: pending strobe is discarded, never emitted.
- programCondition low or CS_N high: no strobes, internalFF holds.

Test Plan:
- RESET pulse while wr to 1000 is active -> all outputs 0 during reset and the cycle after; internalFF=0.
- CS_N=0, programCondition=1, IOW_N=0 for one cycle at A=1000 -> loadCommandReg=1 for exactly the next cycle; all other strobes 0.
- Write A=0010 twice, then A=0011 once -> loadBaseAddressReg pulses twice with channelSelect=01; internalFF goes 0->1->0->1; loadBaseWordCountReg pulses once.
- internalFF=1, write A=1100 -> clearInternalFF pulses; internalFF=0 next cycle. Repeat with A=1101 -> masterClear pulses; internalFF=0.
- Read A=1000 -> readStatusReg=1 and loadIoDataBufferFromStatus=1 the next cycle. Read A=0111 -> readCurrentWordCountReg=1 with channelSelect=11.
- IOW_N=0 and IOR_N=0 together, or programCondition=0 with valid write -> no strobe; internalFF unchanged.

Source files
------------

// File: rtl/reference_model_if.sv
// CPU programming-interface bundle for the 8237 decode model:
// bus-side strobes/address in, registered register-access strobes out.
interface reference_model_if;
   logic       CS_N;
   logic       IOR_N;
   logic       IOW_N;
   logic       A3;
   logic       A2;
   logic       A1;
   logic       A0;
   logic       programCondition;

   logic       loadBaseAddressReg;
   logic       loadBaseWordCountReg;
   logic       readCurrentAddressReg;
   logic       readCurrentWordCountReg;
   logic [1:0] channelSelect;
   logic       loadCommandReg;
   logic       loadRequestReg;
   logic       loadSingleMask;
   logic       loadModeReg;
   logic       clearInternalFF;
   logic       masterClear;
   logic       clearMaskReg;
   logic       loadAllMask;
   logic       readStatusReg;
   logic       readTemporaryReg;
   logic       loadIoDataBufferFromStatus;
   logic       internalFF;

   modport master (
      output CS_N, IOR_N, IOW_N, A3, A2, A1, A0,
      output programCondition,
      input  loadBaseAddressReg, loadBaseWordCountReg,
      input  readCurrentAddressReg, readCurrentWordCountReg,
      input  channelSelect, loadCommandReg, loadRequestReg,
      input  loadSingleMask, loadModeReg, clearInternalFF,
      input  masterClear, clearMaskReg, loadAllMask,
      input  readStatusReg, readTemporaryReg,
      input  loadIoDataBufferFromStatus, internalFF
   );

   modport slave (
      input  CS_N, IOR_N, IOW_N, A3, A2, A1, A0,
      input  programCondition,
      output loadBaseAddressReg, loadBaseWordCountReg,
      output readCurrentAddressReg, readCurrentWordCountReg,
      output channelSelect, loadCommandReg, loadRequestReg,
      output loadSingleMask, loadModeReg, clearInternalFF,
      output masterClear, clearMaskReg, loadAllMask,
      output readStatusReg, readTemporaryReg,
      output loadIoDataBufferFromStatus, internalFF
   );
endinterface

// File: rtl/reference_model.sv
// 8237 DMA program-condition register decode: one-cycle registered
// load/read strobes, channel select and byte-pointer flip-flop.
module reference_model (
   input  logic CLK,
   input  logic RESET,
   reference_model_if.slave bus
);

   localparam int LBA   = 0;
   localparam int LWC   = 1;
   localparam int RCA   = 2;
   localparam int RCW   = 3;
   localparam int LCMD  = 4;
   localparam int LREQ  = 5;
   localparam int LSMSK = 6;
   localparam int LMODE = 7;
   localparam int CLRFF = 8;
   localparam int MCLR  = 9;
   localparam int CLRMK = 10;
   localparam int LAMSK = 11;
   localparam int RSTAT = 12;
   localparam int RTEMP = 13;

   logic [3:0]  addr;
   logic        access;
   logic        wr;
   logic        rd;
   logic        chan_acc;
   logic        ff_clr;
   logic [13:0] strb_d, strb_q;
   logic [1:0]  chsel_d, chsel_q;
   logic        ff_d, ff_q;

   assign addr     = {bus.A3, bus.A2, bus.A1, bus.A0};
   assign access   = !bus.CS_N && bus.programCondition;
   assign wr       = access && !bus.IOW_N && bus.IOR_N;
   assign rd       = access && !bus.IOR_N && bus.IOW_N;
   assign chan_acc = (wr || rd) && !addr[3];
   // 1100 and 1101 both reset the byte pointer
   assign ff_clr   = wr && (addr[3:1] == 3'b110);

   always_comb begin
      strb_d = '0;
      if (wr) begin
         unique casez (addr)
            4'b0??0: strb_d[LBA]   = 1'b1;
            4'b0??1: strb_d[LWC]   = 1'b1;
            4'b1000: strb_d[LCMD]  = 1'b1;
            4'b1001: strb_d[LREQ]  = 1'b1;
            4'b1010: strb_d[LSMSK] = 1'b1;
            4'b1011: strb_d[LMODE] = 1'b1;
            4'b1100: strb_d[CLRFF] = 1'b1;
            4'b1101: strb_d[MCLR]  = 1'b1;
            4'b1110: strb_d[CLRMK] = 1'b1;
            4'b1111: strb_d[LAMSK] = 1'b1;
            default: strb_d        = '0;
         endcase
      end else if (rd) begin
         casez (addr)
            4'b0??0: strb_d[RCA]   = 1'b1;
            4'b0??1: strb_d[RCW]   = 1'b1;
            4'b1000: strb_d[RSTAT] = 1'b1;
            4'b1101: strb_d[RTEMP] = 1'b1;
            default: strb_d        = '0;
         endcase
      end
   end

   always_comb begin
      chsel_d = chsel_q;
      ff_d    = ff_q;
      if (chan_acc) begin
         chsel_d = addr[2:1];
         ff_d    = !ff_q;
      end
      if (ff_clr) begin
         ff_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         strb_q  <= '0;
         chsel_q <= '0;
         ff_q    <= 1'b0;
      end else begin
         strb_q  <= strb_d;
         chsel_q <= chsel_d;
         ff_q    <= ff_d;
      end
   end

   assign bus.loadBaseAddressReg         = strb_q[LBA];
   assign bus.loadBaseWordCountReg       = strb_q[LWC];
   assign bus.readCurrentAddressReg      = strb_q[RCA];
   assign bus.readCurrentWordCountReg    = strb_q[RCW];
   assign bus.loadCommandReg             = strb_q[LCMD];
   assign bus.loadRequestReg             = strb_q[LREQ];
   assign bus.loadSingleMask             = strb_q[LSMSK];
   assign bus.loadModeReg                = strb_q[LMODE];
   assign bus.clearInternalFF            = strb_q[CLRFF];
   assign bus.masterClear                = strb_q[MCLR];
   assign bus.clearMaskReg               = strb_q[CLRMK];
   assign bus.loadAllMask                = strb_q[LAMSK];
   assign bus.readStatusReg              = strb_q[RSTAT];
   assign bus.readTemporaryReg           = strb_q[RTEMP];
   assign bus.loadIoDataBufferFromStatus = strb_q[RSTAT];
   assign bus.channelSelect              = chsel_q;
   assign bus.internalFF                 = ff_q;

endmodule

// File: tb/tb_reference_model.sv
// Directed bench for reference_model: table-driven spec model compared
// every cycle, plus hand-computed literal expectations.
module tb_reference_model;

   logic CLK;
   logic RESET;
   int   checks;
   int   errors;
   bit   run;

   reference_model_if bus ();

   reference_model dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Strobe vector, bit order: LBA LWC RCA RCW CMD REQ SMSK MODE
   // CLRFF MCLR CLRMASK ALLMASK STATUS TEMP
   logic [13:0] dut_vec;
   assign dut_vec = {bus.readTemporaryReg, bus.readStatusReg,
                     bus.loadAllMask, bus.clearMaskReg,
                     bus.masterClear, bus.clearInternalFF,
                     bus.loadModeReg, bus.loadSingleMask,
                     bus.loadRequestReg, bus.loadCommandReg,
                     bus.readCurrentWordCountReg,
                     bus.readCurrentAddressReg,
                     bus.loadBaseWordCountReg,
                     bus.loadBaseAddressReg};

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Spec model: write addr 0..7 -> LBA/LWC by A0, 8..15 -> bits 4..11;
   // read addr 0..7 -> RCA/RCW, 8 -> status, 13 -> temporary.
   function automatic logic [13:0] exp_strobes(bit w, bit r, int a);
      logic [13:0] v;
      v = '0;
      if (w) begin
         if (a < 8) v[a % 2] = 1'b1;
         else       v[a - 4] = 1'b1;
      end else if (r) begin
         if (a < 8)        v[2 + a % 2] = 1'b1;
         else if (a == 8)  v[12] = 1'b1;
         else if (a == 13) v[13] = 1'b1;
      end
      return v;
   endfunction

   int  m_a;
   bit  m_acc, m_w, m_r;
   assign m_a   = {28'd0, bus.A3, bus.A2, bus.A1, bus.A0};
   assign m_acc = !bus.CS_N && bus.programCondition;
   assign m_w   = m_acc && !bus.IOW_N && bus.IOR_N;
   assign m_r   = m_acc && !bus.IOR_N && bus.IOW_N;

   logic [13:0] m_strb;
   logic [1:0]  m_chan;
   logic        m_ff;

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         m_strb <= '0;
         m_chan <= '0;
         m_ff   <= 1'b0;
      end else begin
         m_strb <= exp_strobes(m_w, m_r, m_a);
         if ((m_w || m_r) && m_a < 8) begin
            m_chan <= 2'((m_a >> 1) & 3);
            m_ff   <= !m_ff;
         end
         if (m_w && (m_a == 12 || m_a == 13))
            m_ff <= 1'b0;
      end
   end

   always @(negedge CLK) begin
      if (run) begin
         chk("model strobes", {2'b0, dut_vec}, {2'b0, m_strb});
         chk("model chan", {14'b0, bus.channelSelect}, {14'b0, m_chan});
         chk("model ff", {15'b0, bus.internalFF}, {15'b0, m_ff});
         chk("status buf", {15'b0, bus.loadIoDataBufferFromStatus},
             {15'b0, m_strb[12]});
         chk("onehot", {15'b0, ($countones(dut_vec) > 1)}, 16'd0);
      end
   end

   task automatic setin(input logic cs_n, input logic pc,
                        input logic iow_n, input logic ior_n,
                        input logic [3:0] a);
      bus.CS_N             = cs_n;
      bus.programCondition = pc;
      bus.IOW_N            = iow_n;
      bus.IOR_N            = ior_n;
      {bus.A3, bus.A2, bus.A1, bus.A0} = a;
   endtask

   task automatic drv(input logic cs_n, input logic pc,
                      input logic iow_n, input logic ior_n,
                      input logic [3:0] a);
      setin(cs_n, pc, iow_n, ior_n, a);
      @(posedge CLK);
      #2;
   endtask

   task automatic lit(input string nm, input logic [13:0] v,
                      input logic [1:0] ch, input logic ff);
      chk({nm, " vec"}, {2'b0, dut_vec}, {2'b0, v});
      chk({nm, " chan"}, {14'b0, bus.channelSelect}, {14'b0, ch});
      chk({nm, " ff"}, {15'b0, bus.internalFF}, {15'b0, ff});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      run    = 1'b0;
      RESET  = 1'b1;
      setin(1, 1, 1, 1, 4'h0);
      @(posedge CLK);
      #2;
      run = 1'b1;
      lit("reset idle", 14'h0000, 2'd0, 1'b0);

      // write 1000 while reset held
      drv(0, 1, 0, 1, 4'h8);
      lit("reset wr", 14'h0000, 2'd0, 1'b0);
      RESET = 1'b0;
      #2;
      lit("after reset", 14'h0000, 2'd0, 1'b0);
      drv(1, 1, 1, 1, 4'h0);
      lit("post reset edge", 14'h0000, 2'd0, 1'b0);

      drv(0, 1, 0, 1, 4'h8);
      lit("cmd", 14'h0010, 2'd0, 1'b0);
      chk("cmd bit", {15'b0, bus.loadCommandReg}, 16'd1);
      drv(1, 1, 1, 1, 4'h0);
      lit("cmd end", 14'h0000, 2'd0, 1'b0);

      drv(0, 1, 0, 1, 4'h2);
      lit("lba1", 14'h0001, 2'd1, 1'b1);
      drv(0, 1, 0, 1, 4'h2);
      lit("lba2", 14'h0001, 2'd1, 1'b0);
      drv(0, 1, 0, 1, 4'h3);
      lit("lwc", 14'h0002, 2'd1, 1'b1);
      drv(1, 1, 1, 1, 4'h0);
      lit("hold", 14'h0000, 2'd1, 1'b1);

      drv(0, 1, 0, 1, 4'hC);
      lit("clrff", 14'h0100, 2'd1, 1'b0);
      drv(0, 1, 0, 1, 4'h0);
      lit("lba0", 14'h0001, 2'd0, 1'b1);
      drv(0, 1, 0, 1, 4'hD);
      lit("mclr", 14'h0200, 2'd0, 1'b0);

      drv(0, 1, 1, 0, 4'h8);
      lit("status", 14'h1000, 2'd0, 1'b0);
      chk("iobuf", {15'b0, bus.loadIoDataBufferFromStatus}, 16'd1);
      drv(0, 1, 1, 0, 4'h7);
      lit("rcw", 14'h0008, 2'd3, 1'b1);

      drv(0, 1, 0, 0, 4'h2);
      lit("both low", 14'h0000, 2'd3, 1'b1);
      drv(0, 0, 0, 1, 4'h2);
      lit("no pc", 14'h0000, 2'd3, 1'b1);
      drv(1, 1, 0, 1, 4'h2);
      lit("no cs", 14'h0000, 2'd3, 1'b1);
      drv(0, 1, 1, 0, 4'hD);
      lit("temp", 14'h2000, 2'd3, 1'b1);
      drv(0, 1, 1, 0, 4'h9);
      lit("rd none", 14'h0000, 2'd3, 1'b1);

      // strobe already out, then reset kills it
      drv(0, 1, 0, 1, 4'hF);
      lit("allmask", 14'h0800, 2'd3, 1'b1);
      RESET = 1'b1;
      #1;
      lit("rst kill", 14'h0000, 2'd0, 1'b0);
      #2;
      RESET = 1'b0;
      setin(1, 1, 1, 1, 4'h0);
      @(posedge CLK);
      #2;
      lit("rst gone", 14'h0000, 2'd0, 1'b0);

      // pending decode discarded by a reset pulse before the edge
      setin(0, 1, 0, 1, 4'hF);
      #3;
      RESET = 1'b1;
      #2;
      RESET = 1'b0;
      setin(1, 1, 1, 1, 4'h0);
      @(posedge CLK);
      #2;
      lit("pending", 14'h0000, 2'd0, 1'b0);

      for (int a = 0; a < 16; a++) drv(0, 1, 0, 1, 4'(a));
      for (int a = 0; a < 16; a++) drv(0, 1, 1, 0, 4'(a));
      for (int a = 0; a < 16; a++) begin
         drv(0, 1, 0, 1, 4'(a));
         drv(1, 1, 1, 1, 4'(a));
      end
      drv(1, 1, 1, 1, 4'h0);
      drv(1, 1, 1, 1, 4'h0);

      run = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
